// File: rtl/handshake_tx_queue_if.sv
// Stream and synchronizer-side signals of handshake_tx_queue, bundled for port use.
// In_data moves on every cycle where In_valid && In_ready; In_ready never depends on In_valid.
interface handshake_tx_queue_if #(
  parameter int WORD_LENGTH = 8
) ();
  logic [WORD_LENGTH-1:0] In_data;
  logic                   In_valid;
  logic                   In_ready;
  logic [WORD_LENGTH-1:0] Tx_data;
  logic                   Send_data;
  logic                   Sending;
  logic                   Data_sent;

  modport slave (
    input  In_data, In_valid, Sending, Data_sent,
    output In_ready, Tx_data, Send_data
  );

  modport master (
    output In_data, In_valid, Sending, Data_sent,
    input  In_ready, Tx_data, Send_data
  );
endinterface

// File: rtl/handshake_tx_queue.sv
// Transmit-side FIFO feeding a four-phase handshake synchronizer; one word in flight
// at a time, popped only when the synchronizer confirms delivery with Data_sent.
module handshake_tx_queue #(
  parameter int WORD_LENGTH = 8,
  parameter int DEPTH       = 4
) (
  input  logic                         Clock,
  input  logic                         Reset,
  handshake_tx_queue_if.slave          bus,
  output logic [$clog2(DEPTH+1)-1:0]   Count,
  output logic [15:0]                  Words_sent,
  output logic [1:0]                   Fsm_state
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  if (WORD_LENGTH <= 0) begin : g_bad_width
    $error("handshake_tx_queue: WORD_LENGTH must be > 0");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("handshake_tx_queue: DEPTH must be a power of 2 and >= 2");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    ARM    = 2'd2,
    BUSY   = 2'd3
  } state_t;

  state_t state, state_next;

  logic [WORD_LENGTH-1:0] mem [DEPTH];
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;

  logic push;
  logic pop;
  logic launch;

  assign bus.In_ready = (Count != FULL_CNT);
  assign push         = bus.In_valid && bus.In_ready;
  assign Fsm_state    = state;

  // State register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:    state_next = launch ? LAUNCH : IDLE;
      LAUNCH:  state_next = ARM;
      ARM:     state_next = bus.Sending ? BUSY : ARM;
      BUSY:    state_next = bus.Data_sent ? IDLE : BUSY;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: a launch needs a stored word and a quiet synchronizer;
  // completions are honoured only once the synchronizer has acknowledged busy.
  always_comb begin
    launch = 1'b0;
    pop    = 1'b0;
    case (state)
      IDLE:    launch = (Count != '0) && !bus.Sending;
      BUSY:    pop    = bus.Data_sent;
      default: begin
        launch = 1'b0;
        pop    = 1'b0;
      end
    endcase
  end

  // Registered launch port; Tx_data is only touched on a launch edge
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      bus.Send_data <= 1'b0;
      bus.Tx_data   <= '0;
    end else begin
      bus.Send_data <= launch;
      if (launch) begin
        bus.Tx_data <= mem[rd_ptr];
      end
    end
  end

  // Storage array carries no reset: stale words are unreachable once pointers clear
  always_ff @(posedge Clock) begin
    if (push) begin
      mem[wr_ptr] <= bus.In_data;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      Count      <= '0;
      Words_sent <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr     <= rd_ptr + PW'(1);
        Words_sent <= Words_sent + 16'd1;
      end
      if (push && !pop) begin
        Count <= Count + CW'(1);
      end else if (pop && !push) begin
        Count <= Count - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_handshake_tx_queue.sv
// Bench for handshake_tx_queue: directed producer stimulus, a four-phase synchronizer
// model, and a scoreboard that checks every launched word against the accepted order.
module tb_handshake_tx_queue;

  localparam int W = 8;
  localparam int D = 4;

  logic        Clock;
  logic        Reset;
  logic [2:0]  Count;
  logic [15:0] Words_sent;
  logic [1:0]  Fsm_state;

  handshake_tx_queue_if #(.WORD_LENGTH(W)) bus ();

  handshake_tx_queue #(.WORD_LENGTH(W), .DEPTH(D)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .bus        (bus.slave),
    .Count      (Count),
    .Words_sent (Words_sent),
    .Fsm_state  (Fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- synchronizer model / monitor ----------------
  int       m_st   = 0;
  int       m_cnt  = 0;
  int       m_lat  = 2;
  bit       m_stall = 0;
  bit       m_rand  = 0;
  int       spur_req = 0;
  int       spur_ack = 0;
  logic [W-1:0] m_word;

  always @(negedge Clock) begin
    if (Reset) begin
      m_st          = 0;
      bus.Sending   = 1'b0;
      bus.Data_sent = 1'b0;
      spur_ack      = spur_req;
    end else begin
      case (m_st)
        0: begin
          if (bus.Send_data) begin
            if (exp_q.size() == 0) chk("unexpected_launch", 32'(bus.Tx_data), 32'hFFFF_FFFF);
            else chk("tx_order", 32'(bus.Tx_data), 32'(exp_q.pop_front()));
            m_word = bus.Tx_data;
            m_st   = 1;
          end else if (spur_req != spur_ack) begin
            bus.Sending   = 1'b1;
            bus.Data_sent = 1'b1;
            spur_ack      = spur_req;
            m_st          = 3;
          end
        end
        1: begin
          chk("send_width", 32'(bus.Send_data), 32'd0);
          bus.Sending = 1'b1;
          m_cnt = m_rand ? int'($urandom_range(2, 9)) : m_lat;
          m_st  = 2;
        end
        2: begin
          if (!m_stall) begin
            if (m_cnt > 1) m_cnt--;
            else begin
              chk("tx_stable", 32'(bus.Tx_data), 32'(m_word));
              bus.Data_sent = 1'b1;
              m_st = 3;
            end
          end
        end
        default: begin
          bus.Data_sent = 1'b0;
          bus.Sending   = 1'b0;
          m_st          = 0;
        end
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_word(input logic [W-1:0] d);
    int t = 0;
    @(negedge Clock);
    bus.In_valid = 1'b1;
    bus.In_data  = d;
    while (!bus.In_ready && t < 300) begin
      @(negedge Clock);
      t++;
    end
    if (!bus.In_ready) begin
      chk("push_timeout", 32'(bus.In_ready), 32'd1);
      bus.In_valid = 1'b0;
    end else begin
      @(posedge Clock);
      #1;
      exp_q.push_back(d);
      bus.In_valid = 1'b0;
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge Clock);
    #2;
    Reset        = 1'b1;
    bus.In_valid = 1'b0;
    repeat (cycles) @(negedge Clock);
    exp_q.delete();
    m_stall = 0;
    m_rand  = 0;
    Reset   = 1'b0;
  endtask

  task automatic wait_sent(input logic [15:0] n);
    int t = 0;
    while (Words_sent !== n && t < 2000) begin
      @(negedge Clock);
      t++;
    end
    #1;
    chk("words_sent_reached", 32'(Words_sent), 32'(n));
  endtask

  task automatic wait_data_sent();
    int t = 0;
    @(negedge Clock);
    #1;
    while (bus.Data_sent !== 1'b1 && t < 300) begin
      @(negedge Clock);
      #1;
      t++;
    end
    chk("data_sent_seen", 32'(bus.Data_sent), 32'd1);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    Reset         = 1'b1;
    bus.In_valid  = 1'b0;
    bus.In_data   = '0;
    bus.Sending   = 1'b0;
    bus.Data_sent = 1'b0;

    // Reset then idle
    repeat (3) begin
      @(negedge Clock);
      chk("rst_send_data", 32'(bus.Send_data), 32'd0);
    end
    Reset = 1'b0;
    repeat (3) @(negedge Clock);
    chk("rst_in_ready", 32'(bus.In_ready), 32'd1);
    chk("rst_tx_data", 32'(bus.Tx_data), 32'd0);
    chk("rst_send_idle", 32'(bus.Send_data), 32'd0);
    chk("rst_count", 32'(Count), 32'd0);
    chk("rst_words_sent", 32'(Words_sent), 32'd0);

    // Single word: accepted at edge k, Send_data high after edge k+1
    push_word(8'hA5);
    @(negedge Clock);
    chk("latency_k", 32'(bus.Send_data), 32'd0);
    @(negedge Clock);
    chk("latency_k1", 32'(bus.Send_data), 32'd1);
    chk("single_tx_data", 32'(bus.Tx_data), 32'hA5);
    wait_sent(16'd1);
    chk("single_count", 32'(Count), 32'd0);

    // Fill and drain with synchronizer stalled
    do_reset(2);
    m_stall = 1;
    for (int i = 1; i <= 4; i++) push_word(W'(i));
    @(negedge Clock);
    chk("full_count", 32'(Count), 32'd4);
    chk("full_in_ready", 32'(bus.In_ready), 32'd0);
    fork
      begin
        push_word(8'h05);
        push_word(8'h06);
      end
      begin
        repeat (5) @(negedge Clock);
        #1;
        chk("waiting_in_ready", 32'(bus.In_ready), 32'd0);
        m_stall = 0;
      end
    join
    wait_sent(16'd6);
    chk("drain_count", 32'(Count), 32'd0);
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);

    // Push on Data_sent cycle while full: refused that cycle
    do_reset(2);
    m_stall = 1;
    for (int i = 0; i < 4; i++) push_word(8'h11 + W'(i));
    @(negedge Clock);
    bus.In_valid = 1'b1;
    bus.In_data  = 8'h77;
    m_stall = 0;
    wait_data_sent();
    chk("full_pop_in_ready", 32'(bus.In_ready), 32'd0);
    @(negedge Clock);
    #1;
    chk("full_pop_count", 32'(Count), 32'd3);
    chk("full_pop_ready_after", 32'(bus.In_ready), 32'd1);
    @(posedge Clock);
    #1;
    exp_q.push_back(8'h77);
    bus.In_valid = 1'b0;
    @(negedge Clock);
    chk("refill_count", 32'(Count), 32'd4);
    wait_sent(16'd5);

    // Push and pop on the same edge at Count = 2
    do_reset(2);
    m_stall = 1;
    push_word(8'h21);
    push_word(8'h22);
    @(negedge Clock);
    chk("two_count", 32'(Count), 32'd2);
    m_stall = 0;
    wait_data_sent();
    bus.In_valid = 1'b1;
    bus.In_data  = 8'h33;
    @(posedge Clock);
    #1;
    exp_q.push_back(8'h33);
    bus.In_valid = 1'b0;
    @(negedge Clock);
    chk("push_pop_count", 32'(Count), 32'd2);
    wait_sent(16'd3);

    // Asynchronous reset mid-transfer
    do_reset(2);
    m_stall = 1;
    for (int i = 0; i < 3; i++) push_word(8'hC0 + W'(i));
    repeat (4) @(negedge Clock);
    #1;
    chk("busy_count", 32'(Count), 32'd3);
    #2;
    Reset = 1'b1;
    #1;
    chk("async_in_ready", 32'(bus.In_ready), 32'd1);
    chk("async_send_data", 32'(bus.Send_data), 32'd0);
    chk("async_tx_data", 32'(bus.Tx_data), 32'd0);
    chk("async_count", 32'(Count), 32'd0);
    chk("async_words_sent", 32'(Words_sent), 32'd0);
    repeat (2) @(negedge Clock);
    exp_q.delete();
    m_stall = 0;
    Reset   = 1'b0;
    spur_req++;
    repeat (5) @(negedge Clock);
    #1;
    chk("spurious_words_sent", 32'(Words_sent), 32'd0);
    chk("spurious_count", 32'(Count), 32'd0);
    chk("spurious_send_data", 32'(bus.Send_data), 32'd0);

    // Pointer wrap with random gaps and random synchronizer latency
    do_reset(2);
    m_rand = 1;
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge Clock);
      push_word(W'($urandom_range(0, 255)));
    end
    wait_sent(16'd20);
    chk("wrap_count", 32'(Count), 32'd0);
    chk("wrap_queue_empty", 32'(exp_q.size()), 32'd0);

    repeat (3) @(negedge Clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
